// File: rtl/mul_pkg.sv
// Shared widths and payload types for the nibble multiplier.
package mul_pkg;

  localparam int unsigned MUL_IN_W  = 4;
  localparam int unsigned MUL_OUT_W = 8;

  typedef logic [MUL_IN_W-1:0]  nibble_t;
  typedef logic [MUL_OUT_W-1:0] prod_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; a half adder is this cell with cin tied low.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/mul_4x4.sv
// Unsigned 4x4 array multiplier: AND array, three rippling adder rows,
// and a synchronously reset product register.
module mul_4x4
  import mul_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MUL_IN_W-1:0]  x,
  input  logic [MUL_IN_W-1:0]  y,
  output logic [MUL_OUT_W-1:0] out
);

  localparam int unsigned NROWS = MUL_IN_W;

  nibble_t pp         [NROWS];
  nibble_t row_sum    [NROWS];
  nibble_t row_addend [1:NROWS-1];
  nibble_t row_c      [1:NROWS-1];
  logic    row_msb    [NROWS];
  prod_t   prod_d;
  prod_t   out_q;

  // Partial products: row i is x gated by multiplier bit y[i].
  for (genvar i = 0; i < int'(NROWS); i++) begin : g_pp_row
    for (genvar j = 0; j < int'(MUL_IN_W); j++) begin : g_pp_bit
      assign pp[i][j] = x[j] & y[i];
    end
  end

  assign row_sum[0] = pp[0];
  assign row_msb[0] = 1'b0;

  // Each row adds its partial products to the previous row's sum shifted
  // right by one; the dropped LSB is a finished product bit.
  for (genvar i = 1; i < int'(NROWS); i++) begin : g_row
    assign row_addend[i] = {row_msb[i-1], row_sum[i-1][MUL_IN_W-1:1]};
    assign row_msb[i]    = row_c[i][MUL_IN_W-1];

    for (genvar j = 0; j < int'(MUL_IN_W); j++) begin : g_cell
      logic cin;
      if (j == 0) begin : g_half
        assign cin = 1'b0;
      end else begin : g_full
        assign cin = row_c[i][j-1];
      end

      full_adder u_fa (
        .a    (pp[i][j]),
        .b    (row_addend[i][j]),
        .cin  (cin),
        .sum  (row_sum[i][j]),
        .cout (row_c[i][j])
      );
    end
  end

  assign prod_d = {row_msb[NROWS-1], row_sum[NROWS-1],
                   row_sum[2][0], row_sum[1][0], row_sum[0][0]};

  // Product register; reset takes priority over the new product.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= prod_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_mul_4x4.sv
// Self-checking bench for mul_4x4: directed corners, reset behaviour,
// exhaustive sweep and random pairs against an arithmetic reference.
module tb_mul_4x4;

  logic       clk;
  logic       rst;
  logic [3:0] x;
  logic [3:0] y;
  logic [7:0] out_w;

  int unsigned total;
  int unsigned passed;

  mul_4x4 dut (
    .clk (clk),
    .rst (rst),
    .x   (x),
    .y   (y),
    .out (out_w)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_mul(input int unsigned a, input int unsigned b);
    return 8'(a * b);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
  endtask

  // Drive operands/reset, take one rising edge, sample 1 time unit later.
  task automatic step(input logic r, input logic [3:0] xv, input logic [3:0] yv);
    rst = r;
    x   = xv;
    y   = yv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] rx;
    logic [3:0] ry;
    clk    = 1'b0;
    total  = 0;
    passed = 0;

    // Reset held for two edges with max operands present.
    step(1'b1, 4'hF, 4'hF);
    check("rst_edge1", out_w, 8'h00);
    step(1'b1, 4'hF, 4'hF);
    check("rst_edge2", out_w, 8'h00);
    step(1'b0, 4'hF, 4'hF);
    check("post_rst_ff", out_w, 8'hE1);

    // Directed products.
    step(1'b0, 4'b0100, 4'b1000);
    check("dir_4x8", out_w, 8'd32);
    step(1'b0, 4'b0101, 4'b0011);
    check("dir_5x3", out_w, 8'd15);

    // Corners.
    step(1'b0, 4'h0, 4'hA);
    check("zero_x", out_w, 8'd0);
    step(1'b0, 4'h1, 4'hD);
    check("one_x", out_w, 8'd13);
    step(1'b0, 4'hF, 4'h1);
    check("one_y", out_w, 8'd15);
    step(1'b0, 4'hF, 4'hF);
    check("max", out_w, 8'd225);

    // Back-to-back operand changes.
    step(1'b0, 4'd2, 4'd3);
    check("b2b_0", out_w, 8'd6);
    step(1'b0, 4'd7, 4'd9);
    check("b2b_1", out_w, 8'd63);
    step(1'b0, 4'd12, 4'd11);
    check("b2b_2", out_w, 8'd132);

    // Mid-stream reset coinciding with an operand change: reset wins.
    step(1'b0, 4'd2, 4'd3);
    check("mid_pre", out_w, 8'd6);
    step(1'b1, 4'd7, 4'd9);
    check("mid_rst", out_w, 8'd0);
    step(1'b0, 4'd12, 4'd11);
    check("mid_resume", out_w, 8'd132);

    // Exhaustive sweep.
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 4'(i >> 4), 4'(i));
      check("exhaustive", out_w, ref_mul(32'(i >> 4), 32'(i & 15)));
    end

    // Random pairs with occasional reset pulses.
    for (int i = 0; i < 200; i++) begin
      rx = 4'($urandom_range(15, 0));
      ry = 4'($urandom_range(15, 0));
      if ($urandom_range(19, 0) == 0) begin
        step(1'b1, rx, ry);
        check("rand_rst", out_w, 8'h00);
      end else begin
        step(1'b0, rx, ry);
        check("random", out_w, ref_mul(32'(rx), 32'(ry)));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
